// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI initiator for 16-bit register-bank and pass-through frames.
// MISO readback is built only when SPI_REG_MASTER_READBACK_EN is defined.

module spi_reg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_special,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_val,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        sclk,
  output logic        cs_n,
  output logic        special_n,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_REL   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [7:0] H_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] tx_q, tx_d;
  logic        spec_q, spec_d;

  logic ready_q;
  logic sclk_q;
  logic cs_n_q;
  logic special_n_q;
  logic mosi_q;
  logic rsp_valid_q;

  logic phase_end;
  logic accept;
  logic cs_on;
  logic spec_on;
  logic cap_en;

  assign phase_end = (cnt_q == H_LAST);
  assign accept    = cmd_valid && ready_q;
  assign cap_en    = (state_q == S_HI) && phase_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = phase_end ? 8'd0 : cnt_q + 8'd1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    spec_d  = spec_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d = 8'd0;
        if (state_q == S_DONE)
          state_d = S_IDLE;
        if (accept) begin
          state_d = S_SETUP;
          bit_d   = 5'd0;
          tx_d    = {cmd_addr, cmd_val};
          spec_d  = cmd_special;
        end
      end
      S_SETUP: begin
        if (phase_end)
          state_d = S_HI;
      end
      S_HI: begin
        if (phase_end) begin
          state_d = S_LO;
          tx_d    = {tx_q[14:0], 1'b0};
          bit_d   = bit_q + 5'd1;
        end
      end
      S_LO: begin
        if (phase_end)
          state_d = (bit_q == 5'd16) ? S_HOLD : S_HI;
      end
      S_HOLD: begin
        if (phase_end)
          state_d = S_REL;
      end
      S_REL: begin
        if (phase_end)
          state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // SPECIAL stays asserted through RELEASE so it brackets the CS rise.
  assign cs_on = (state_d == S_SETUP) || (state_d == S_HI) ||
                 (state_d == S_LO) || (state_d == S_HOLD);
  assign spec_on = spec_d && (cs_on || (state_d == S_REL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd0;
      tx_q    <= 16'd0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      spec_q  <= spec_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      special_n_q <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      ready_q     <= (state_d == S_IDLE) || (state_d == S_DONE);
      sclk_q      <= (state_d == S_HI);
      cs_n_q      <= ~cs_on;
      special_n_q <= ~spec_on;
      mosi_q      <= cs_on ? tx_d[15] : 1'b0;
      rsp_valid_q <= (state_d == S_DONE);
    end
  end

`ifdef SPI_REG_MASTER_READBACK_EN
  logic [15:0] rx_q;
  logic [15:0] rsp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q  <= 16'd0;
      rsp_q <= 16'd0;
    end else begin
      if (cap_en)
        rx_q <= {rx_q[14:0], miso};
      if ((state_q == S_REL) && (state_d == S_DONE))
        rsp_q <= rx_q;
    end
  end

  assign rsp_data = rsp_q;
`else
  logic unused_rb;
  assign unused_rb = miso ^ cap_en;
  assign rsp_data  = 16'd0;
`endif

  assign cmd_ready = ready_q;
  assign busy      = ~ready_q;
  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign special_n = special_n_q;
  assign mosi      = mosi_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: scoreboard bench with a register-bank responder model.
// Expected rsp_data follows SPI_REG_MASTER_READBACK_EN.

module tb_spi_reg_master;

  localparam int H     = 2;
  localparam int FRAME = 35 * H + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_special = 1'b0;
  logic [7:0]  cmd_addr = 8'd0;
  logic [7:0]  cmd_val = 8'd0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic        special_n;
  logic        mosi;
  logic        miso = 1'b0;

  spi_reg_master #(.CLK_DIV(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_special(cmd_special), .cmd_addr(cmd_addr), .cmd_val(cmd_val),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .special_n(special_n),
    .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Set nibble v[3:0], clear nibble v[7:4]; both set toggles the bit.
  function automatic logic [3:0] apply_sc(logic [3:0] old, logic [7:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      case ({v[4+i], v[i]})
        2'b11:   r[i] = ~old[i];
        2'b01:   r[i] = 1'b1;
        2'b10:   r[i] = 1'b0;
        default: r[i] = old[i];
      endcase
    end
    return r;
  endfunction

  logic [3:0] bank [256];
  logic [3:0] ref_regs [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      bank[i] = 4'd0;
      ref_regs[i] = 4'd0;
    end
  end

  // Responder: register bank plus MISO driver on the falling-edge schedule
  logic [15:0] miso_pat = 16'd0;
  logic [15:0] mosi_word = 16'd0;
  logic [15:0] out_shift = 16'd0;
  int nrise = 0, first_rise = 0, cs_fall = 0, cs_last = 0;
  int sp_first = 0, sp_last = 0, sclk_edges = 0;
  bit sp_any = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (sclk !== prev_sclk) sclk_edges++;
    if (prev_cs && !cs_n) begin
      nrise = 0;
      mosi_word = 16'd0;
      out_shift = miso_pat;
      miso = miso_pat[15];
      cs_fall = cyc;
      sp_any = 0;
      first_rise = -1;
    end
    if (!cs_n) begin
      cs_last = cyc;
      if (!prev_sclk && sclk) begin
        if (nrise == 0) first_rise = cyc;
        mosi_word = {mosi_word[14:0], mosi};
        nrise++;
      end
      if (prev_sclk && !sclk) begin
        out_shift = {out_shift[14:0], 1'b0};
        miso = out_shift[15];
      end
    end
    if (!special_n) begin
      if (!sp_any) sp_first = cyc;
      sp_any = 1;
      sp_last = cyc;
    end
    if (!prev_cs && cs_n && nrise == 16 && !special_n)
      bank[mosi_word[15:8]] = apply_sc(bank[mosi_word[15:8]], mosi_word[7:0]);
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  typedef struct {
    bit          special;
    logic [7:0]  addr;
    logic [15:0] word;
    logic [15:0] rsp;
    logic [3:0]  reg_exp;
    int          acc;
  } exp_t;

  exp_t sb[$];

  task automatic issue(bit sp, logic [7:0] a, logic [7:0] v, logic [15:0] pat);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < FRAME * 4) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      check("cmd_ready wait", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    miso_pat = pat;
    cmd_valid = 1'b1;
    cmd_special = sp;
    cmd_addr = a;
    cmd_val = v;
    if (sp) ref_regs[a] = apply_sc(ref_regs[a], v);
    e.special = sp;
    e.addr = a;
    e.word = {a, v};
`ifdef SPI_REG_MASTER_READBACK_EN
    e.rsp = pat;
`else
    e.rsp = 16'd0;
`endif
    e.reg_exp = ref_regs[a];
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_special = 1'($urandom);
    cmd_addr = 8'($urandom);
    cmd_val = 8'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < FRAME * 20) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard drained", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every completion
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rsp_valid && prev_rv)
      check("rsp_valid pulse width", 32'd2, 32'd1);
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected rsp_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.rsp);
        check("mosi word", mosi_word, e.word);
        check("sclk rises", nrise, 16);
        check("first rise cycle", first_rise - e.acc, 1 + H);
        check("cs_n first low", cs_fall - e.acc, 1);
        check("cs_n last low", cs_last - e.acc, 34 * H);
        check("rsp_valid cycle", cyc - e.acc, FRAME);
        check("cmd_ready at done", {31'd0, cmd_ready}, 32'd1);
        if (e.special) begin
          check("special_n first low", sp_first - e.acc, 1);
          check("special_n last low", sp_last - e.acc, 35 * H);
        end else begin
          check("special_n idle on passthru", {31'd0, sp_any}, 32'd0);
        end
        check("bank reg", bank[e.addr], e.reg_exp);
      end
    end
    prev_rv = rsp_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] saved;
    int e0, t;
    bit sp;
    logic [7:0] a;
    repeat (3) @(negedge clk);
    check("reset cs_n", {31'd0, cs_n}, 32'd1);
    check("reset special_n", {31'd0, special_n}, 32'd1);
    check("reset sclk", {31'd0, sclk}, 32'd0);
    check("reset mosi", {31'd0, mosi}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("idle busy", {31'd0, busy}, 32'd0);
    e0 = sclk_edges;
    repeat (100) @(negedge clk);
    check("idle sclk edges", sclk_edges - e0, 0);
    check("idle cs_n", {31'd0, cs_n}, 32'd1);

    issue(1'b1, 8'h07, 8'h03, 16'($urandom));
    drain();
    check("reg_led after set", bank[8'h07], 4'h3);
    issue(1'b1, 8'h07, 8'h11, 16'hA5C3);
    drain();
    check("reg_led after toggle", bank[8'h07], 4'h2);
    e0 = sclk_edges;
    issue(1'b0, 8'h9F, 8'h00, 16'($urandom));
    drain();
    check("passthru sclk edges", sclk_edges - e0, 32);
    check("passthru bank 9F", bank[8'h9F], 4'h0);
    check("passthru reg_led", bank[8'h07], 4'h2);

    // Back-to-back random frames
    for (int i = 0; i < 10; i++) begin
      sp = 1'($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 1) != 0) ? 8'h07 : 8'($urandom_range(0, 15));
      issue(sp, a, 8'($urandom), 16'($urandom));
    end
    drain();

    // Abort a register frame after its 8th rising edge
    saved = ref_regs[8'h05];
    issue(1'b1, 8'h05, 8'h0F ^ {4'h0, saved}, 16'($urandom));
    t = 0;
    @(negedge clk); #1;
    while (nrise < 8 && t < FRAME * 2) begin
      @(negedge clk); #1;
      t++;
    end
    check("reached 8th edge", nrise, 8);
    rst_n = 1'b0;
    #1;
    check("abort cs_n", {31'd0, cs_n}, 32'd1);
    check("abort sclk", {31'd0, sclk}, 32'd0);
    ref_regs[8'h05] = saved;
    if (sb.size() != 0) void'(sb.pop_back());
    repeat (3) @(negedge clk);
    check("abort busy during reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort bank unchanged", bank[8'h05], saved);
    issue(1'b1, 8'h05, 8'h0F, 16'($urandom));
    drain();
    check("post-abort bank", bank[8'h05], 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI initiator that issues 16-bit register-bank frames (address byte + set/clear value byte) and plain pass-through frames, generating CS, SPECIAL, SCLK and MOSI and capturing MISO. It is the controller end of the FPGA register-bank SPI link. It is used as an on-board sequencer and as the bench driver for register-bank verification. It runs entirely in the system clock domain and synthesises SCLK by division.

## Interface

Parameters:
- CLK_DIV, 4, system clock cycles per SCLK half-period (H); legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_special  in  1  1 = register-bank frame (SPECIAL asserted); 0 = pass-through frame to the muxed peripheral.
- cmd_addr  in  8  frame bits 15:8.
- cmd_val  in  8  frame bits 7:0; [3:0] = set nibble, [7:4] = clear nibble, both set = toggle.
- rsp_valid  out  1  one-cycle pulse at frame completion.
- rsp_data  out  16  MISO bits captured during the frame, first bit in bit 15; held until the next completion.
- busy  out  1  equals ~cmd_ready.
- sclk  out  1  SPI clock, idle low.
- cs_n  out  1  chip select, active-low.
- special_n  out  1  SPECIAL, active-low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in; sampled synchronously.

## Operation

- Reset: cs_n=1, special_n=1, sclk=0, mosi=0, rsp_valid=0, rsp_data=0, state IDLE. cmd_ready=0 while rst_n is low and 1 from the first clock after release.
- On accept, the block latches {cmd_addr, cmd_val} into a 16-bit shift register and latches cmd_special. Input changes during a frame have no effect. cmd_valid while busy is ignored.
- State machine:
  - IDLE: wait for accept.
  - SETUP: H cycles. cs_n=0, special_n=~cmd_special, mosi=bit 15, sclk=0.
  - SHIFT_HI: H cycles, sclk=1. Data is stable; the responder samples on the falling edge that ends this phase.
  - SHIFT_LO: H cycles, sclk=0.
    - On entry, the MISO value present in the last SHIFT_HI cycle is shifted into the capture register LSB.
    - mosi is updated to the next bit on entry to SHIFT_LO.
    - SHIFT_HI/SHIFT_LO repeat 16 times, counted by a 5-bit bit counter.
  - HOLD: H cycles. sclk=0, cs_n=0. At exit, cs_n=1.
  - RELEASE: H cycles. cs_n=1, special_n still at its frame value. At exit, special_n=1.
  - DONE: 1 cycle. rsp_valid=1, rsp_data updated, then IDLE.
- SPECIAL always brackets CS: it is asserted no later than cs_n falls and released at least H cycles after cs_n rises. This guarantees the responder's CS-rise commit sees SPECIAL asserted.
- Exactly 16 SCLK rising edges occur per frame.
- Pass-through frames (cmd_special=0) keep special_n=1 throughout; the timing is otherwise identical.
- Asynchronous reset mid-frame immediately drives cs_n=1 with fewer than 16 edges, so the responder discards the frame. No rsp_valid is produced.

## Timing

- Cycle numbers are relative to the accept cycle (cycle 0).
- cs_n is low on cycles 1..34H.
- special_n is low on cycles 1..35H (register frames only).
- sclk rising edges occur at cycles 1+H+2kH, k=0..15. Falling edges occur H cycles after each rising edge.
- rsp_valid=1 on cycle 35H+1.
- cmd_ready is 1 on cycle 35H+1. A back-to-back accept there gives cs_n high for H+1 cycles minimum.
- Total frame period is 35H+1 cycles: 141 cycles at CLK_DIV=4.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- SPI_REG_MASTER_READBACK_EN
  - Defined: MISO capture and rsp_data operate as above.
  - Undefined: the capture register is not built, rsp_data is constant 0, and miso is unused. rsp_valid timing is unchanged.

## Test plan

- Reset, then an idle check. Required: cs_n=1, special_n=1, sclk=0, mosi=0, cmd_ready=1; no sclk edges for 100 cycles.
- CLK_DIV=2, register frame addr=0x07, val=0x03 into a register-bank model. Required:
  - mosi bits 0x0703 MSB first.
  - cs_n low cycles 1..68, special_n low cycles 1..70, rsp_valid at cycle 71.
  - Model reg_led=0x3.
- Then addr=0x07, val=0x11 (toggle bit 0). Required: model reg_led=0x2.
- Readback: model drives miso with pattern 0xA5C3 on the falling-edge schedule. Required: rsp_data=0xA5C3. With the macro undefined: rsp_data=0.
- Pass-through frame, cmd_special=0, addr=0x9F, val=0x00. Required: special_n stays 1 throughout, 16 sclk pulses, register-bank model unchanged.
- Assert rst_n low after the 8th sclk rising edge. Required:
  - cs_n=1 and sclk=0 within the same cycle.
  - No rsp_valid.
  - Model registers unchanged.
  - The next full frame completes normally.
